// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode values, sequencer state encoding, ALU
// operation classes and default widths used by the ctrl/alu/sequencer blocks.
package sisc_pkg;

    localparam int unsigned OPW_DEF      = 4;
    localparam int unsigned STATW_DEF    = 4;
    localparam int unsigned WAIT_MAX_DEF = 15;
    localparam int unsigned CNTW_DEF     = 16;

    // Opcodes at the default 4-bit width; HLT is all-ones at any width.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ALU = 4'h1;
    localparam logic [3:0] OP_BRA = 4'h2;
    localparam logic [3:0] OP_BRR = 4'h4;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ST_START0 = 3'd0;
    localparam logic [2:0] ST_START1 = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_DECODE = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_MEM    = 3'd5;
    localparam logic [2:0] ST_WB     = 3'd6;
    localparam logic [2:0] ST_HALT   = 3'd7;

    typedef enum logic [2:0] {
        S_START0 = ST_START0,
        S_START1 = ST_START1,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT
    } state_e;

    localparam logic [1:0] ALU_OP_NONE  = 2'b00;
    localparam logic [1:0] ALU_OP_ARITH = 2'b01;

endpackage

// File: rtl/sisc_seq_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and
// instruction memory (slave).
interface sisc_seq_if;
    logic imem_req;
    logic imem_rdy;

    modport master (output imem_req, input imem_rdy);
    modport slave  (input imem_req, output imem_rdy);
endinterface

// File: rtl/sisc_seq_wdog.sv
// FETCH wait-state watchdog: counts enabled cycles and flags the cycle in
// which the count would reach the limit.
module sisc_seq_wdog (
    input  logic       clk,
    input  logic       rst_f,
    input  logic       cnt_en,
    input  logic       clr,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] cnt_r;

    // Consecutive wait counter, saturating so it can never wrap back to zero.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            cnt_r <= 8'd0;
        end else if (clr) begin
            cnt_r <= 8'd0;
        end else if (cnt_en && (cnt_r != 8'hFF)) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Fires in the limit-th wait cycle so the sequencer leaves at that edge.
    assign expired = cnt_en && (cnt_r == (limit - 8'd1));

endmodule

// File: rtl/sisc_seq.sv
// SISC multi-cycle sequencer with fetch handshake, watchdog and HALT state.
// Optional retired-instruction counter is built when SISC_SEQ_PERF_EN is defined.
module sisc_seq
    import sisc_pkg::*;
#(
    parameter int unsigned OPW      = OPW_DEF,
    parameter int unsigned STATW    = STATW_DEF,
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF,
    parameter int unsigned CNTW     = CNTW_DEF
) (
    input  logic              clk,
    input  logic              rst_f,
    sisc_seq_if.master        imem,
    input  logic [OPW-1:0]    opcode,
    input  logic [STATW-1:0]  mm,
    input  logic [STATW-1:0]  stat,
    output logic              ir_load,
    output logic              pc_write,
    output logic              pc_sel,
    output logic              pc_rst,
    output logic              br_sel,
    output logic              rb_sel,
    output logic              rf_we,
    output logic              wb_sel,
    output logic [1:0]        alu_op,
    output logic              stat_en,
    output logic              halted,
    output logic              fault,
    output logic [CNTW-1:0]   ret_cnt
);

    localparam logic [7:0]     WAIT_LIM = 8'(WAIT_MAX);
    localparam logic [OPW-1:0] HLT_CODE = {OPW{1'b1}};

    state_e state_r;
    state_e next_s;
    logic   imem_req_s;
    logic   is_alu_s, is_bra_s, is_brr_s, is_hlt_s;
    logic   taken_s;
    logic   wd_en_s, wd_clr_s, wd_expired_s;
    logic   fault_set_s, retire_s;
    logic   fault_r;

    assign is_alu_s = (opcode == OPW'(OP_ALU));
    assign is_bra_s = (opcode == OPW'(OP_BRA));
    assign is_brr_s = (opcode == OPW'(OP_BRR));
    assign is_hlt_s = (opcode == HLT_CODE);
    assign taken_s  = (mm == {STATW{1'b0}}) || ((stat & mm) != {STATW{1'b0}});

    assign wd_en_s     = (state_r == S_FETCH) && !imem.imem_rdy;
    assign wd_clr_s    = (state_r != S_FETCH);
    assign fault_set_s = wd_en_s && wd_expired_s;
    assign retire_s    = (state_r == S_WB) || ((state_r == S_DECODE) && is_hlt_s);

    sisc_seq_wdog u_wdog (
        .clk     (clk),
        .rst_f   (rst_f),
        .cnt_en  (wd_en_s),
        .clr     (wd_clr_s),
        .limit   (WAIT_LIM),
        .expired (wd_expired_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_r <= S_START0;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and control decode; illegal opcodes fall through as NOP.
    always_comb begin
        next_s     = state_r;
        imem_req_s = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        pc_rst     = 1'b0;
        br_sel     = 1'b0;
        rb_sel     = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = 1'b0;
        alu_op     = ALU_OP_NONE;
        stat_en    = 1'b0;
        halted     = 1'b0;
        case (state_r)
            S_START0: begin
                pc_rst = 1'b1;
                next_s = S_START1;
            end
            S_START1: begin
                next_s = S_FETCH;
            end
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (imem.imem_rdy) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    next_s   = S_DECODE;
                end else if (wd_expired_s) begin
                    next_s = S_HALT;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (is_hlt_s) begin
                    next_s = S_HALT;
                end else begin
                    next_s = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_alu_s) begin
                    alu_op  = ALU_OP_ARITH;
                    stat_en = 1'b1;
                end else begin
                    alu_op  = ALU_OP_NONE;
                end
                next_s = S_MEM;
            end
            S_MEM: begin
                if ((is_bra_s || is_brr_s) && taken_s) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = is_bra_s;
                end else begin
                    pc_write = 1'b0;
                end
                next_s = S_WB;
            end
            S_WB: begin
                if (is_alu_s) begin
                    rf_we = 1'b1;
                end else begin
                    rf_we = 1'b0;
                end
                next_s = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                next_s = S_HALT;
            end
            default: begin
                next_s = S_START0;
            end
        endcase
    end

    assign imem.imem_req = imem_req_s;

    // Sticky watchdog fault; only reset clears it.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            fault_r <= 1'b0;
        end else if (fault_set_s) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign fault = fault_r;

`ifdef SISC_SEQ_PERF_EN
    logic [CNTW-1:0] ret_r;

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            ret_r <= {CNTW{1'b0}};
        end else if (retire_s) begin
            ret_r <= ret_r + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            ret_r <= ret_r;
        end
    end

    assign ret_cnt = ret_r;
`else
    logic unused_retire_s;
    assign unused_retire_s = retire_s;
    assign ret_cnt         = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_sisc_seq.sv
// Scoreboard bench for sisc_seq: stimulus queues per-cycle expected control
// vectors, a negedge monitor pops and compares them.
module tb_sisc_seq;

    logic        clk;
    logic        rst_f;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [3:0]  stat;
    logic        ir_load, pc_write, pc_sel, pc_rst, br_sel, rb_sel;
    logic        rf_we, wb_sel, stat_en, halted, fault;
    logic [1:0]  alu_op;
    logic [15:0] ret_cnt;
    logic [15:0] rc;
    logic [29:0] act;

    int n_chk = 0;
    int n_err = 0;

    logic [29:0] exp_q[$];
    string       tag_q[$];

    sisc_seq_if imem ();

    sisc_seq #(.OPW(4), .STATW(4), .WAIT_MAX(3), .CNTW(16)) dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .imem     (imem),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .ir_load  (ir_load),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .pc_rst   (pc_rst),
        .br_sel   (br_sel),
        .rb_sel   (rb_sel),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .alu_op   (alu_op),
        .stat_en  (stat_en),
        .halted   (halted),
        .fault    (fault),
        .ret_cnt  (ret_cnt)
    );

    assign act = {imem.imem_req, ir_load, pc_write, pc_sel, pc_rst, br_sel, rb_sel,
                  rf_we, wb_sel, alu_op, stat_en, halted, fault, ret_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] mk(input logic req, ir, pcw, pcs, pcr, brs, rfw,
                                       input logic [1:0] aop, input logic sen, hlt, flt,
                                       input logic [15:0] r);
        return {req, ir, pcw, pcs, pcr, brs, 1'b0, rfw, 1'b0, aop, sen, hlt, flt, r};
    endfunction

    function automatic void chk(input string name, input logic [29:0] got, input logic [29:0] e);
        n_chk++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, e);
        end
    endfunction

    always @(negedge clk) begin : mon
        logic [29:0] e;
        string       t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, act, e);
        end
    end

    task automatic expect_now(input logic [29:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic cyc(input logic [29:0] e, input string tag);
        expect_now(e, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic bump();
`ifdef SISC_SEQ_PERF_EN
        rc = rc + 16'd1;
`endif
    endtask

    task automatic reset_release();
        @(posedge clk);
        #1;
        rst_f = 1'b1;
        rc    = 16'd0;
        imem.imem_rdy = 1'b1;
        cyc(mk(0,0,0,0,1,0,0,2'b00,0,0,0,16'd0), "start0");
        cyc(mk(0,0,0,0,0,0,0,2'b00,0,0,0,16'd0), "start1");
    endtask

    task automatic async_reset(input string tag);
        rst_f = 1'b0;
        #1;
        chk(tag, act, mk(0,0,0,0,1,0,0,2'b00,0,0,0,16'd0));
        reset_release();
    endtask

    task automatic do_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                            input int nwait, input logic tk, input logic abort);
        logic alu;
        logic bra;
        alu    = (op == 4'h1);
        bra    = (op == 4'h2);
        opcode = op;
        mm     = m;
        stat   = s;
        for (int i = 0; i < nwait; i++) begin
            imem.imem_rdy = 1'b0;
            cyc(mk(1,0,0,0,0,0,0,2'b00,0,0,0,rc), "fetch_wait");
        end
        imem.imem_rdy = 1'b1;
        cyc(mk(1,1,1,0,0,0,0,2'b00,0,0,0,rc), "fetch");
        cyc(mk(0,0,0,0,0,0,0,2'b00,0,0,0,rc), "decode");
        cyc(mk(0,0,0,0,0,0,0,alu ? 2'b01 : 2'b00,alu,0,0,rc), "execute");
        cyc(mk(0,0,tk,tk,0,tk & bra,0,2'b00,0,0,0,rc), "mem");
        if (abort) begin
            expect_now(mk(0,0,0,0,0,0,alu,2'b00,0,0,0,rc), "wb_pre_abort");
            @(negedge clk);
            #2;
            async_reset("wb_abort");
        end else begin
            cyc(mk(0,0,0,0,0,0,alu,2'b00,0,0,0,rc), "wb");
            bump();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rc     = 16'd0;
        rst_f  = 1'b1;
        opcode = 4'h0;
        mm     = 4'h0;
        stat   = 4'h0;
        imem.imem_rdy = 1'b1;
        #2;
        rst_f = 1'b0;
        #1;
        chk("reset_async", act, mk(0,0,0,0,1,0,0,2'b00,0,0,0,16'd0));
        reset_release();

        do_instr(4'h1, 4'h0, 4'h0, 0, 1'b0, 1'b0);
        do_instr(4'h1, 4'h0, 4'h0, 2, 1'b0, 1'b0);
        do_instr(4'h0, 4'h0, 4'h0, 2, 1'b0, 1'b0);
        do_instr(4'h4, 4'b0010, 4'b0010, 0, 1'b1, 1'b0);
        do_instr(4'h4, 4'b0010, 4'b0100, 0, 1'b0, 1'b0);
        do_instr(4'h2, 4'b0000, 4'b0000, 1, 1'b1, 1'b0);
        do_instr(4'h2, 4'b0001, 4'b1110, 0, 1'b0, 1'b0);
        do_instr(4'h2, 4'b0110, 4'b0100, 0, 1'b1, 1'b0);
        do_instr(4'h7, 4'b0000, 4'b0000, 0, 1'b0, 1'b0);
        do_instr(4'h1, 4'h0, 4'h0, 0, 1'b0, 1'b1);

        opcode = 4'h1;
        imem.imem_rdy = 1'b0;
        repeat (3) cyc(mk(1,0,0,0,0,0,0,2'b00,0,0,0,rc), "wdog_wait");
        repeat (3) cyc(mk(0,0,0,0,0,0,0,2'b00,0,1,1,rc), "wdog_halt");
        async_reset("wdog_reset");

        opcode = 4'hF;
        imem.imem_rdy = 1'b1;
        cyc(mk(1,1,1,0,0,0,0,2'b00,0,0,0,rc), "hlt_fetch");
        cyc(mk(0,0,0,0,0,0,0,2'b00,0,0,0,rc), "hlt_decode");
        bump();
        repeat (20) cyc(mk(0,0,0,0,0,0,0,2'b00,0,1,0,rc), "halt_hold");
        async_reset("halt_reset");

        do_instr(4'h1, 4'h0, 4'h0, 0, 1'b0, 1'b0);

        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
